// File: rtl/seg_pipe_adder.sv
// rtl/seg_pipe_adder.sv - segmented pipelined add/subtract, one SEG-bit slice per stage
// Resolved low bits grow stage by stage while unresolved high operand bits shrink as a skew buffer.
module seg_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int NSEG = WIDTH / SEG;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Whole pipe advances together; a full output slot with no taker freezes every stage.
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !reset;
    assign b_eff    = op_sub ? ~b : b;
    assign c0       = op_sub | cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int RW = LO + SEG;
        localparam int UW = WIDTH - LO;

        logic          v_in;
        logic          c_in;
        logic [UW-1:0] a_in;
        logic [UW-1:0] b_in;
        logic [SEG:0]  seg_sum;
        logic [RW-1:0] res_nxt;

        logic          v_q;
        logic          c_q;
        logic [RW-1:0] res_q;

        if (k == 0) begin : g_first
            assign v_in    = in_valid;
            assign c_in    = c0;
            assign a_in    = a;
            assign b_in    = b_eff;
            assign res_nxt = seg_sum[SEG-1:0];
        end else begin : g_next
            assign v_in    = g_stg[k-1].v_q;
            assign c_in    = g_stg[k-1].c_q;
            assign a_in    = g_stg[k-1].g_skew.a_q;
            assign b_in    = g_stg[k-1].g_skew.b_q;
            assign res_nxt = {seg_sum[SEG-1:0], g_stg[k-1].res_q};
        end

        assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        // Data registers only load on a valid slot so the last result is held through bubbles.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= seg_sum[SEG];
                    res_q <= res_nxt;
                end
            end
        end

        if (k < NSEG - 1) begin : g_skew
            logic [UW-SEG-1:0] a_q;
            logic [UW-SEG-1:0] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && v_in) begin
                    a_q <= a_in[UW-1:SEG];
                    b_q <= b_in[UW-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stg[NSEG-1].v_q;
    assign sum       = {g_stg[NSEG-1].c_q, g_stg[NSEG-1].res_q};

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into NSEG = WIDTH/SEG segments and computes one segment per pipeline stage, passing the carry stage to stage.
- Throughput is one operation per cycle, with a carry-in, a subtract mode and valid/ready flow control on both sides.
- Sits between operand-producing datapath logic and any consumer that needs wide sums at high clock rates.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of SEG, minimum 2.
- SEG, 4, bits resolved per pipeline stage; 1 <= SEG <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  operands/op/cin valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in; ignored when op_sub=1
- op_sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1
- out_valid  output  1  sum is valid
- out_ready  input  1  consumer accepts sum this cycle
- sum  output  WIDTH+1  result; sum[WIDTH] = carry-out; in subtract mode sum[WIDTH]=1 means no borrow (a>=b)

Behaviour:
- Reset (synchronous, sampled on clk rising edge):
  - All stage valid bits, out_valid and sum clear to 0.
  - Reset dominates in_valid and out_ready in the same cycle.
  - In-flight operations are discarded without any output.
- in_ready is 0 while reset is asserted.
- Global advance enable: en = !out_valid || out_ready. Every stage register loads only when en=1; otherwise all stages hold.
- in_ready = en, combinational from out_valid and out_ready. No combinational path from in_valid to out_valid.
- Transfer rule: an input is taken when in_valid && in_ready; an output is consumed when out_valid && out_ready.
- Operand preparation at entry: b_eff = op_sub ? ~b : b; c0 = op_sub ? 1 : cin.
- Pipeline structure:
  - Stage k (k=0..NSEG-1) adds segment k of a and b_eff, bits [k*SEG +: SEG], plus the carry from stage k-1 (c0 for k=0).
  - Stage k stores the SEG-bit partial sum and the carry-out.
  - The already-resolved lower segments travel forward with the data.
  - The unresolved upper operand segments travel as a skew buffer.
- Stage NSEG-1 drives sum, with sum[WIDTH] = final carry-out.
- Latency: exactly NSEG cycles from the accepting edge to out_valid=1, when no stall occurs.
- Throughput: one operation per cycle while out_ready=1.
- Bubbles: a cycle with in_valid=0 and en=1 inserts an invalid slot that propagates. Bubbles are not collapsed, so ordering and slot spacing are preserved.
- Stall: when out_valid=1 and out_ready=0, sum and out_valid stay stable and all internal stages freeze. in_ready=0 for that cycle.
- Simultaneous accept and consume in one cycle is legal: the pipeline shifts by one and no data is lost.
- Wrap-around: arithmetic is modulo 2^(WIDTH+1) by construction. There is no saturation and no overflow flag. Signed overflow is the consumer's concern.
- SEG=WIDTH degenerates to a single-stage registered adder with latency 1.
- sum is don't-care while out_valid=0, but the implementation holds the last value.

Test Plan (WIDTH=16, SEG=4, latency 4):
- Carry ripple across all segments:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0, op_sub=0, out_ready=1.
  - Required: out_valid rises exactly 4 cycles after acceptance with sum=0x10000; out_valid is high for one cycle only.
- Carry-in and subtract:
  - Stimulus: a=0x1234, b=0x0FFF, cin=1 -> sum=0x02234.
  - Stimulus: a=0x0005, b=0x0007, op_sub=1 -> sum=0x0FFFE (MSB 0, borrow).
  - Stimulus: a=0x0007, b=0x0005, op_sub=1 -> sum=0x10002.
- Back-to-back throughput:
  - Stimulus: 300 consecutive accepts with a=n, b=n<<4, out_ready=1.
  - Required: 300 consecutive out_valid cycles starting 4 cycles after the first accept, each sum = a+b in order.
- Backpressure:
  - Stimulus: stream of 6 operations; out_ready=0 for 3 cycles once out_valid=1.
  - Required: sum stable, in_ready=0 during the stall, no loss or duplication, order preserved after release.
- Bubbles:
  - Stimulus: in_valid pattern 1,0,1,1,0 with out_ready=1.
  - Required: out_valid pattern 1,0,1,1,0 delayed by exactly 4 cycles.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle with 3 operations in flight.
  - Required: out_valid=0 and sum=0 on the next edge, none of the 3 results ever appear, and a new operation after reset emerges after 4 cycles.
